demux_gen: RTL and testbench

Serial-to-parallel distributor: accepts one `BUS_DATA_SIZE`-bit word per handshake and steers it into lane `idx` of an N-lane register bank. When N words have arrived, or a word flagged last has arrived, the bank is presented as one flattened N-lane block. It is the inverse of the N-entry selection mux in the mode datapath, and it uses the same lane ordering: lane 0 occupies the LSBs. It sits between the byte/word input stream and the wide state/block registers.

---
 rtl/demux_gen_pkg.sv | 18 +
 rtl/demux_dec.sv | 20 ++
 rtl/demux_gen.sv | 91 +++++++++
 tb/tb_demux_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_gen_pkg.sv
// demux_gen shared definitions: state encoding and width helpers
// used by both the distributor and the selection mux users.
package demux_gen_pkg;

  typedef enum logic {
    DMX_FILL = 1'b0,
    DMX_FULL = 1'b1
  } dmx_state_e;

  function automatic int dmx_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dmx_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/demux_dec.sv
// Binary-to-one-hot decoder; the counterpart of the
// N-entry selection mux (lane 0 is bit 0).
module demux_dec
  import demux_gen_pkg::*;
#(
  parameter int N     = 7,
  parameter int log2N = dmx_idx_w(N)
) (
  input  logic [log2N-1:0] ctrl,
  output logic [N-1:0]     sel
);

  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      sel[k] = (ctrl == log2N'(k));
    end
  end

endmodule

// File: rtl/demux_gen.sv
// Serial-to-parallel distributor: steers words into an N-lane
// bank and presents it when full or when a last word arrives.
module demux_gen
  import demux_gen_pkg::*;
#(
  parameter int N             = 7,
  parameter int BUS_DATA_SIZE = 1,
  parameter int log2N         = dmx_idx_w(N),
  parameter int CW            = dmx_cnt_w(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BUS_DATA_SIZE-1:0]   din,
  input  logic                       din_valid,
  input  logic                       din_last,
  output logic                       din_ready,
  output logic [N*BUS_DATA_SIZE-1:0] dout,
  output logic [CW-1:0]              dout_cnt,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [log2N-1:0]           fill_idx
);

  localparam int BW = BUS_DATA_SIZE;

  dmx_state_e state_q, state_d;
  logic [log2N-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0][BW-1:0] lane_q, lane_d;
  logic [N-1:0] sel, we;
  logic wr, rd, last;

  assign din_ready  = (state_q == DMX_FILL) | dout_ready;
  assign dout_valid = (state_q == DMX_FULL);
  assign wr = din_valid & din_ready;
  assign rd = dout_valid & dout_ready;
  assign last = din_last | (fill_q == log2N'(N - 1));

  demux_dec #(
    .N     (N),
    .log2N (log2N)
  ) u_dec (
    .ctrl (fill_q),
    .sel  (sel)
  );

  assign we = sel & {N{wr}};

  // fill_q is 0 whenever FULL, so a drain+refill writes lane 0
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    if (rd) begin
      state_d = DMX_FILL;
      lane_d  = '0;
    end
    for (int k = 0; k < N; k++) begin
      if (we[k]) lane_d[k] = din;
    end
    if (wr) begin
      if (last) begin
        state_d = DMX_FULL;
        cnt_d   = CW'(fill_q) + CW'(1);
        fill_d  = '0;
      end else begin
        fill_d  = fill_q + log2N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMX_FILL;
      fill_q  <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  assign dout     = lane_q;
  assign dout_cnt = cnt_q;
  assign fill_idx = fill_q;

endmodule

// File: tb/tb_demux_gen.sv
// Bench for demux_gen: directed scenarios plus random traffic
// against a queue-based block model; N=2 corner on a 2nd instance.
module tb_demux_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        dout_ready = 1'b0;
  logic        din_ready;
  logic [55:0] dout;
  logic [2:0]  dout_cnt;
  logic        dout_valid;
  logic [2:0]  fill_idx;

  logic        d2_din = 1'b0;
  logic        d2_valid = 1'b0;
  logic        d2_last = 1'b0;
  logic        d2_oready = 1'b0;
  logic        d2_iready;
  logic [1:0]  d2_dout;
  logic [1:0]  d2_cnt;
  logic        d2_ovalid;
  logic        d2_fill;

  demux_gen #(.N(7), .BUS_DATA_SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_cnt   (dout_cnt),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fill_idx   (fill_idx)
  );

  demux_gen #(.N(2), .BUS_DATA_SIZE(1)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (d2_din),
    .din_valid  (d2_valid),
    .din_last   (d2_last),
    .din_ready  (d2_iready),
    .dout       (d2_dout),
    .dout_cnt   (d2_cnt),
    .dout_valid (d2_ovalid),
    .dout_ready (d2_oready),
    .fill_idx   (d2_fill)
  );

  int vectors = 0;
  int errs = 0;

  // model: words of the block being collected, and the presented block
  logic [7:0]  cur[$];
  logic        m_valid = 1'b0;
  logic [2:0]  m_cnt = '0;
  logic [55:0] m_blk = '0;

  function automatic logic [55:0] pack(input logic [7:0] q[$]);
    logic [55:0] r;
    r = '0;
    foreach (q[i]) r[i*8 +: 8] = q[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check();
    chk("din_ready", 64'(din_ready), 64'(!m_valid || dout_ready));
    chk("dout_valid", 64'(dout_valid), 64'(m_valid));
    chk("dout_cnt", 64'(dout_cnt), 64'(m_cnt));
    chk("fill_idx", 64'(fill_idx), 64'(m_valid ? 0 : cur.size()));
    chk("dout", 64'(dout), 64'(m_valid ? m_blk : pack(cur)));
  endtask

  task automatic model_reset();
    cur.delete();
    m_valid = 1'b0;
    m_cnt = '0;
    m_blk = '0;
  endtask

  task automatic step(input logic v, input logic l,
                      input logic [7:0] d, input logic r);
    logic ewr;
    @(negedge clk);
    din_valid = v;
    din_last = l;
    din = d;
    dout_ready = r;
    #1 check();
    ewr = v && (!m_valid || r);
    @(posedge clk);
    if (m_valid && r) m_valid = 1'b0;
    if (ewr) begin
      cur.push_back(d);
      if (cur.size() == 7 || l) begin
        m_valid = 1'b1;
        m_cnt = 3'(cur.size());
        m_blk = pack(cur);
        cur.delete();
      end
    end
    #1;
    din_valid = 1'b0;
    din_last = 1'b0;
    dout_ready = 1'b0;
  endtask

  initial begin
    // reset state
    #1 check();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // full block, consumer stalled
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    #2;
    chk("full_valid", 64'(dout_valid), 64'd1);
    chk("full_dout", 64'(dout), 64'h16151413121110);
    chk("full_cnt", 64'(dout_cnt), 64'd7);
    chk("full_stall", 64'(din_ready), 64'd0);
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // short block via last
    step(1'b1, 1'b0, 8'hA1, 1'b0);
    step(1'b1, 1'b0, 8'hA2, 1'b0);
    step(1'b1, 1'b1, 8'hA3, 1'b0);
    #2;
    chk("short_dout", 64'(dout), 64'h0000000000A3A2A1);
    chk("short_cnt", 64'(dout_cnt), 64'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    #2;
    chk("after_rd_fill", 64'(fill_idx), 64'd0);
    chk("after_rd_dout", 64'(dout), 64'd0);

    // 21 back-to-back words
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b1);
    #2;
    chk("b2b_valid", 64'(dout_valid), 64'd1);
    chk("b2b_dout", 64'(dout), 64'h44434241403F3E);

    // drain and refill with a single-word block
    step(1'b1, 1'b1, 8'h5C, 1'b1);
    #2;
    chk("refill_valid", 64'(dout_valid), 64'd1);
    chk("refill_cnt", 64'(dout_cnt), 64'd1);
    chk("refill_dout", 64'(dout), 64'h5C);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // asynchronous reset mid-block
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_fill", 64'(fill_idx), 64'd0);
    chk("arst_dout", 64'(dout), 64'd0);
    check();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    #2;
    chk("clean_dout", 64'(dout), 64'h86858483828180);
    chk("clean_cnt", 64'(dout_cnt), 64'd7);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // N=2, 1-bit lanes
    #2 chk("n2_fill0", 64'(d2_fill), 64'd0);
    @(negedge clk);
    d2_valid = 1'b1;
    d2_din = 1'b1;
    @(posedge clk);
    #2 chk("n2_fill1", 64'(d2_fill), 64'd1);
    @(negedge clk);
    d2_din = 1'b0;
    @(posedge clk);
    #1 d2_valid = 1'b0;
    #1;
    chk("n2_fill_wrap", 64'(d2_fill), 64'd0);
    chk("n2_valid", 64'(d2_ovalid), 64'd1);
    chk("n2_dout", 64'(d2_dout), 64'b01);
    chk("n2_cnt", 64'(d2_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
